// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with round-robin and starvation override
module cdb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8,
  parameter int SRC_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [31:0]               bcast_count,
  output logic                      tag0_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  wait_cnt [NUM_REQ];
  logic [SRC_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] starve;
  logic              grant_any;
  logic [SRC_W-1:0]  winner;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  // Pick the winner: lowest starving unit first, otherwise first valid unit from rr_ptr onward.
  always_comb begin
    starve    = '0;
    grant_any = 1'b0;
    winner    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starve[i] = req_valid[i] && (wait_cnt[i] == CNT_W'(MAX_WAIT));
    end
    if (!reset && !flush) begin
      if (|starve) begin
        // Descending scan so the lowest starving index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (starve[i]) begin
            winner    = SRC_W'(i);
            grant_any = 1'b1;
          end
        end
      end else begin
        // Descending offset so the unit closest to rr_ptr is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            winner    = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            grant_any = 1'b1;
          end
        end
      end
    end
    req_ready = grant_any ? (NUM_REQ'(1) << winner) : '0;
    sel_tag   = req_tag[int'(winner) * TAG_W +: TAG_W];
    sel_data  = req_data[int'(winner) * DATA_W +: DATA_W];
  end

  // Pointer, wait counters and the registered broadcast stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      bcast_count <= '0;
      tag0_err    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (grant_any) begin
        rr_ptr <= SRC_W'((int'(winner) + 1) % NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush || !req_valid[i] || (grant_any && winner == SRC_W'(i))) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_W'(MAX_WAIT)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      if (grant_any) begin
        if (sel_tag != '0) begin
          cdb_valid   <= 1'b1;
          cdb_tag     <= sel_tag;
          cdb_data    <= sel_data;
          cdb_src     <= winner;
          bcast_count <= bcast_count + 32'd1;
        end else begin
          // Tag 0 names no producer: consume it silently and remember the protocol error.
          tag0_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [19:0] req_tag;
  logic [63:0] req_data;

  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [31:0] bcast_count;
  logic        tag0_err;

  logic [3:0]  s_ready;
  logic        s_cdb_valid;
  logic [4:0]  s_cdb_tag;
  logic [15:0] s_cdb_data;
  logic [1:0]  s_cdb_src;
  logic [31:0] s_bcast_count;
  logic        s_tag0_err;

  int passed = 0;
  int total = 0;
  int exp_cnt = 0;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .bcast_count(bcast_count),
    .tag0_err(tag0_err)
  );

  // Small starvation threshold so the override path is reachable despite round-robin.
  cdb_arbiter #(.MAX_WAIT(1)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(s_ready), .cdb_valid(s_cdb_valid), .cdb_tag(s_cdb_tag),
    .cdb_data(s_cdb_data), .cdb_src(s_cdb_src), .bcast_count(s_bcast_count),
    .tag0_err(s_tag0_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       flush;
    logic [3:0] valid;
    logic [3:0] ready;
    logic       cv;
    logic [4:0] tag;
    logic [1:0] src;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic default_payload();
    req_tag  = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data = {16'hD0D3, 16'hD0D2, 16'hD0D1, 16'hD0D0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; req_valid = 4'b1111;
    #1;
    check("ready during reset", req_ready, 4'b0000);
    @(posedge clk); #1;
    check("reset cdb_valid", cdb_valid, 0);
    check("reset cdb_tag", cdb_tag, 0);
    check("reset cdb_data", cdb_data, 0);
    check("reset cdb_src", cdb_src, 0);
    check("reset bcast_count", bcast_count, 0);
    check("reset tag0_err", tag0_err, 0);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b0000;
    exp_cnt = 0;
  endtask

  initial begin
    default_payload();
    //                flush valid    ready    cv  tag   src
    tbl[0]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 5'd1, 2'd0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 5'd2, 2'd1};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 5'd3, 2'd2};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 5'd4, 2'd3};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 5'd1, 2'd0};
    tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 5'd2, 2'd1};
    tbl[6]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 5'd4, 2'd3};
    tbl[7]  = '{1'b0, 4'b1001, 4'b0001, 1'b1, 5'd1, 2'd0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0, 2'd0};
    tbl[9]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 5'd0, 2'd0};
    tbl[10] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 5'd2, 2'd1};
    tbl[11] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 5'd3, 2'd2};
    tbl[12] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 5'd0, 2'd0};
    tbl[13] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 5'd4, 2'd3};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 5'd0, 2'd0};

    do_reset();

    // Single request on unit 2.
    @(negedge clk);
    req_tag[14:10] = 5'd5; req_data[47:32] = 16'h1234; req_valid = 4'b0100;
    #1;
    check("single ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    check("single cdb_valid", cdb_valid, 1);
    check("single cdb_tag", cdb_tag, 5);
    check("single cdb_data", cdb_data, 16'h1234);
    check("single cdb_src", cdb_src, 2);
    check("single bcast_count", bcast_count, 1);
    @(negedge clk);
    req_valid = 4'b0000; default_payload();
    @(posedge clk); #1;
    check("single drop cdb_valid", cdb_valid, 0);

    do_reset();

    // Round-robin, pointer, idle and flush vectors.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      flush = tbl[i].flush; req_valid = tbl[i].valid;
      #1;
      check($sformatf("v%0d req_ready", i), req_ready, tbl[i].ready);
      @(posedge clk); #1;
      if (tbl[i].cv) exp_cnt++;
      check($sformatf("v%0d cdb_valid", i), cdb_valid, tbl[i].cv);
      check($sformatf("v%0d cdb_tag", i), cdb_tag, tbl[i].tag);
      check($sformatf("v%0d cdb_src", i), cdb_src, tbl[i].src);
      check($sformatf("v%0d cdb_data", i), cdb_data, tbl[i].cv ? 16'hD0D0 + 16'(tbl[i].src) : 16'h0);
      check($sformatf("v%0d bcast_count", i), bcast_count, exp_cnt);
    end
    flush = 1'b0;

    // Tag 0 grant on unit 1 (pointer is at 0).
    @(negedge clk);
    req_tag[9:5] = 5'd0; req_valid = 4'b0010;
    #1;
    check("tag0 ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    check("tag0 cdb_valid", cdb_valid, 0);
    check("tag0 tag0_err", tag0_err, 1);
    check("tag0 bcast_count", bcast_count, exp_cnt);

    @(negedge clk);
    default_payload(); req_valid = 4'b1111;
    #1;
    check("post-tag0 ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    check("post-tag0 cdb_tag", cdb_tag, 3);
    check("tag0_err sticky", tag0_err, 1);

    // Reset in the middle of continuous requests.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    check("midreset cdb_valid", cdb_valid, 0);
    check("midreset cdb_tag", cdb_tag, 0);
    check("midreset cdb_data", cdb_data, 0);
    check("midreset bcast_count", bcast_count, 0);
    check("midreset tag0_err", tag0_err, 0);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b1110;
    #1;
    check("first after reset ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    check("first after reset src", cdb_src, 1);
    check("first after reset count", bcast_count, 1);

    // Starvation override on the MAX_WAIT=1 instance.
    do_reset();
    @(negedge clk);
    req_valid = 4'b1101;
    #1;
    check("starve A ready", s_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b1110;
    #1;
    check("starve B ready", s_ready, 4'b0100);
    check("starve B rr ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    check("starve B src", s_cdb_src, 2);
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    check("starve C ready", s_ready, 4'b0010);
    @(negedge clk);
    flush = 1'b1; req_valid = 4'b1111;
    #1;
    check("starve D flush ready", s_ready, 4'b0000);
    @(negedge clk);
    flush = 1'b0; req_valid = 4'b0011;
    #1;
    check("starve E ready", s_ready, 4'b0001);
    @(posedge clk); #1;
    check("starve E src", s_cdb_src, 0);

    @(negedge clk);
    req_valid = 4'b0000;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
